lru_ctrl_2way: RTL and testbench
================================

LRU_CTRL_2WAY -- requirements
Module: lru_ctrl_2way

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 SHALL have the following ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where req_valid & req_ready.
- req_index  in  6  set index.
- req_kind  in  2  00 touch, 01 allocate, 10 query, 11 reserved (treated as query).
- req_way  in  1  way that hit; used by touch only.
- flush  in  1  level-sampled command to clear all 64 LRU bits.
- busy  out  1  high while in FLUSH.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_victim  out  1  victim way; meaningful only while resp_valid is high.
- lru_addr  out  6  LRU storage address.
- lru_wdata  out  1  LRU storage write data.
- lru_we  out  1  LRU storage write enable.
- lru_rdata  in  1  LRU storage combinational read data at lru_addr.

Function
REQ-003 SHALL treat each LRU bit as the way to evict next (0 = way0, 1 = way1); the storage writes on the clock edge and reads combinationally.
REQ-004 SHALL implement two states, IDLE and FLUSH.
REQ-005 SHALL drive req_ready = (state==IDLE) & ~flush, combinationally.
REQ-006 SHALL register an accepted request (index, kind, way) into a single stage register, stage_valid=1, at the acceptance edge.
REQ-007 SHALL process the stage in the following cycle (latency 1):
- lru_addr = stage index
- resp_valid = 1
REQ-008 SHALL process each request kind in the stage cycle as follows:
- touch: lru_we=1, lru_wdata=~req_way, resp_victim=lru_rdata.
- allocate: resp_victim=lru_rdata, lru_we=1, lru_wdata=~lru_rdata.
- query/reserved: resp_victim=lru_rdata, lru_we=0.
REQ-009 SHALL sustain one request per cycle; a back-to-back request to the same index SHALL observe the value written by its predecessor, because it reads one cycle after that write.
REQ-010 SHALL, when flush=1 is sampled in IDLE, enter FLUSH on that edge; a stage op in flight during that cycle SHALL complete normally in that same cycle.
REQ-011 SHALL give flush priority when flush and req_valid are both high: the request is not accepted.
REQ-012 SHALL, in FLUSH, drive:
- lru_addr = 6-bit sweep counter
- lru_we = 1
- lru_wdata = 0
The counter SHALL increment each cycle from 0 to 63.
REQ-013 SHALL return to IDLE after writing address 63; the counter SHALL wrap to 0; FLUSH lasts exactly 64 cycles.
REQ-014 SHALL ignore flush while in FLUSH (no restart or extension of the sweep).
REQ-015 SHALL drive busy = (state==FLUSH).
REQ-016 SHALL hold resp_valid=0 and lru_we=0 in any cycle with no stage op and not in FLUSH; lru_addr and lru_wdata are don't-care there, but lru_addr SHALL be driven to 0.

Reset
REQ-017 SHALL, while rst=0, asynchronously force state=FLUSH, sweep counter=0 and stage_valid=0.
REQ-018 SHALL hold the following outputs while rst=0:
- req_ready 0
- busy 1
- resp_valid 0
- resp_victim 0
- lru_we 0 (gated by rst)
REQ-019 SHALL, after rst deasserts, perform a full 64-cycle init sweep before req_ready can rise.
REQ-020 SHALL, on reset asserted mid-FLUSH or mid-request, drop the in-flight op with no response and restart the sweep from 0 after deassertion.

Verification
REQ-021 Init sweep: deassert rst -> lru_we=1, lru_wdata=0, lru_addr 0..63 on consecutive cycles; busy high 64 cycles; req_ready=1 on cycle 65.
REQ-022 Allocate/touch: allocate idx 5 (bit=0) -> resp_victim=0 one cycle later, bit becomes 1; allocate idx 5 again -> victim=1, bit becomes 0; touch idx 5 way0 -> bit=1.
REQ-023 Back-to-back: allocate idx 9 on two consecutive cycles -> resp_victim 0 then 1; resp_valid high two consecutive cycles.
REQ-024 Query and reserved kinds: kind 10 and kind 11 on idx 3 -> resp_victim=stored bit, lru_we=0, bit unchanged.
REQ-025 Flush contention: flush=1 and req_valid=1 in the same IDLE cycle -> req_ready=0, request not accepted; in-flight stage response still emitted; busy 64 cycles; all bits read 0 afterwards; flush pulses during the sweep do not extend it.
REQ-026 Mid-op reset: assert rst during the stage cycle and during the sweep at counter 30 -> no resp_valid; outputs at reset values; after release, sweep restarts at address 0.

Source files
------------

// File: rtl/lru_ctrl_2way_if.sv
// Request/response and LRU-storage signals of the 2-way LRU controller.
// slave = controller side, master = requester/storage side.
interface lru_ctrl_2way_if;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_index;
  logic [1:0] req_kind;
  logic       req_way;
  logic       flush;
  logic       busy;
  logic       resp_valid;
  logic       resp_victim;
  logic [5:0] lru_addr;
  logic       lru_wdata;
  logic       lru_we;
  logic       lru_rdata;

  modport slave (
    input  req_valid, req_index, req_kind, req_way, flush, lru_rdata,
    output req_ready, busy, resp_valid, resp_victim, lru_addr, lru_wdata, lru_we
  );

  modport master (
    output req_valid, req_index, req_kind, req_way, flush, lru_rdata,
    input  req_ready, busy, resp_valid, resp_victim, lru_addr, lru_wdata, lru_we
  );
endinterface

// File: rtl/lru_ctrl_2way.sv
// 2-way LRU bit controller: 64 sets, one-stage request pipe, flush sweep.
// Each stored bit names the way to evict next (0 = way0, 1 = way1).
module lru_ctrl_2way (
  input  logic           clk,
  input  logic           rst,
  lru_ctrl_2way_if.slave bus
);
  localparam logic [1:0] K_TOUCH = 2'b00;
  localparam logic [1:0] K_ALLOC = 2'b01;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic       stage_valid;
  logic [5:0] stage_index;
  logic [1:0] stage_kind;
  logic       stage_way;
  logic       accept;

  assign bus.req_ready = (state == IDLE) & ~bus.flush;
  assign bus.busy      = (state == FLUSH);
  assign accept        = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FLUSH;
      cnt         <= 6'd0;
      stage_valid <= 1'b0;
      stage_index <= 6'd0;
      stage_kind  <= 2'b00;
      stage_way   <= 1'b0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_index <= bus.req_index;
        stage_kind  <= bus.req_kind;
        stage_way   <= bus.req_way;
      end
      case (state)
        IDLE:  if (bus.flush) state <= FLUSH;
        FLUSH: begin
          // counter wraps to 0 on the last write, ready for the next sweep
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) state <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

  // stage_valid can never be set in FLUSH: acceptance requires IDLE and no flush
  always_comb begin
    bus.lru_addr    = 6'd0;
    bus.lru_wdata   = 1'b0;
    bus.lru_we      = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_victim = 1'b0;
    if (state == FLUSH) begin
      bus.lru_addr = cnt;
      bus.lru_we   = rst;
    end else if (stage_valid) begin
      bus.lru_addr    = stage_index;
      bus.resp_valid  = 1'b1;
      bus.resp_victim = bus.lru_rdata;
      case (stage_kind)
        K_TOUCH: begin
          bus.lru_we    = 1'b1;
          bus.lru_wdata = ~stage_way;
        end
        K_ALLOC: begin
          bus.lru_we    = 1'b1;
          bus.lru_wdata = ~bus.lru_rdata;
        end
        default: bus.lru_we = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_lru_ctrl_2way.sv
// Self-checking bench for lru_ctrl_2way: directed scenarios plus a random
// request stream checked against a per-set "next victim" table.
module tb_lru_ctrl_2way;
  logic clk;
  logic rst;
  logic [63:0] mem;
  bit   model [64];
  int   n_chk;
  int   n_fail;

  localparam logic [1:0] TOUCH = 2'b00, ALLOC = 2'b01, QUERY = 2'b10, RSVD = 2'b11;

  lru_ctrl_2way_if bus();

  lru_ctrl_2way dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (bus.lru_we) mem[bus.lru_addr] <= bus.lru_wdata;
  assign bus.lru_rdata = mem[bus.lru_addr];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [5:0] idx, input logic w);
    bus.req_valid = v;
    bus.req_kind  = k;
    bus.req_index = idx;
    bus.req_way   = w;
  endtask

  // Sweep writes 0 to 0..63 on consecutive cycles, then the block is ready.
  task automatic check_sweep(input string tag, input bit pulse);
    for (int i = 0; i < 64; i++) begin
      bus.flush = pulse && (i == 10 || i == 40 || i == 63);
      #1;
      n_chk++;
      if (bus.busy !== 1'b1 || bus.lru_we !== 1'b1 || bus.lru_wdata !== 1'b0 ||
          bus.lru_addr !== 6'(i) || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_sweep[%0d] got busy=%b we=%b wd=%b addr=%0d rdy=%b rv=%b exp busy=1 we=1 wd=0 addr=%0d rdy=0 rv=0",
                 tag, i, bus.busy, bus.lru_we, bus.lru_wdata, bus.lru_addr, bus.req_ready, bus.resp_valid, i);
      end
      tick();
    end
    bus.flush = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_sweep_end got busy=%b rdy=%b exp busy=0 rdy=1", tag, bus.busy, bus.req_ready);
    end
    for (int k = 0; k < 64; k++) model[k] = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_chk++;
    if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_victim !== 1'b0 || bus.lru_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got rdy=%b busy=%b rv=%b vic=%b we=%b exp rdy=0 busy=1 rv=0 vic=0 we=0",
               tag, bus.req_ready, bus.busy, bus.resp_valid, bus.resp_victim, bus.lru_we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, ALLOC, 6'd1, 1'b0);
    repeat (3) tick();
    #1;
    check_reset_outputs("reset");
    drive(1'b0, TOUCH, 6'd0, 1'b0);
    rst = 1'b1;
    check_sweep("init", 1'b0);
  endtask

  task automatic test_alloc_touch();
    drive(1'b1, ALLOC, 6'd5, 1'b0); #1;
    n_chk++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL at_ready got=%b exp=1", bus.req_ready); end
    tick();
    drive(1'b0, TOUCH, 6'd0, 1'b0); #1;
    n_chk++;
    if (bus.resp_valid !== 1'b1 || bus.resp_victim !== 1'b0 || bus.lru_we !== 1'b1 ||
        bus.lru_wdata !== 1'b1 || bus.lru_addr !== 6'd5) begin
      n_fail++;
      $display("FAIL alloc1 got rv=%b vic=%b we=%b wd=%b addr=%0d exp rv=1 vic=0 we=1 wd=1 addr=5",
               bus.resp_valid, bus.resp_victim, bus.lru_we, bus.lru_wdata, bus.lru_addr);
    end
    tick();
    drive(1'b1, ALLOC, 6'd5, 1'b0); #1; tick();
    drive(1'b1, TOUCH, 6'd5, 1'b0); #1;
    n_chk++;
    if (bus.resp_valid !== 1'b1 || bus.resp_victim !== 1'b1 || bus.lru_wdata !== 1'b0) begin
      n_fail++;
      $display("FAIL alloc2 got rv=%b vic=%b wd=%b exp rv=1 vic=1 wd=0", bus.resp_valid, bus.resp_victim, bus.lru_wdata);
    end
    tick();
    drive(1'b1, QUERY, 6'd5, 1'b0); #1;
    n_chk++;
    if (bus.resp_valid !== 1'b1 || bus.resp_victim !== 1'b0 || bus.lru_we !== 1'b1 || bus.lru_wdata !== 1'b1) begin
      n_fail++;
      $display("FAIL touch got rv=%b vic=%b we=%b wd=%b exp rv=1 vic=0 we=1 wd=1",
               bus.resp_valid, bus.resp_victim, bus.lru_we, bus.lru_wdata);
    end
    tick();
    drive(1'b0, TOUCH, 6'd0, 1'b0); #1;
    n_chk++;
    if (bus.resp_victim !== 1'b1 || bus.lru_we !== 1'b0) begin
      n_fail++;
      $display("FAIL touch_readback got vic=%b we=%b exp vic=1 we=0", bus.resp_victim, bus.lru_we);
    end
    tick();
    model[5] = 1'b1;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, ALLOC, 6'd9, 1'b0); #1; tick();
    #1;
    n_chk++;
    if (bus.resp_valid !== 1'b1 || bus.resp_victim !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first got rv=%b vic=%b exp rv=1 vic=0", bus.resp_valid, bus.resp_victim);
    end
    tick();
    drive(1'b0, TOUCH, 6'd0, 1'b0); #1;
    n_chk++;
    if (bus.resp_valid !== 1'b1 || bus.resp_victim !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second got rv=%b vic=%b exp rv=1 vic=1", bus.resp_valid, bus.resp_victim);
    end
    tick();
    #1;
    n_chk++;
    if (bus.resp_valid !== 1'b0 || bus.lru_we !== 1'b0 || bus.lru_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL b2b_idle got rv=%b we=%b addr=%0d exp rv=0 we=0 addr=0", bus.resp_valid, bus.lru_we, bus.lru_addr);
    end
    tick();
    model[9] = 1'b0;
  endtask

  task automatic test_query_reserved();
    drive(1'b1, ALLOC, 6'd3, 1'b0); #1; tick();
    drive(1'b1, QUERY, 6'd3, 1'b0); #1; tick();
    drive(1'b1, RSVD, 6'd3, 1'b1); #1;
    n_chk++;
    if (bus.resp_valid !== 1'b1 || bus.resp_victim !== 1'b1 || bus.lru_we !== 1'b0) begin
      n_fail++;
      $display("FAIL query got rv=%b vic=%b we=%b exp rv=1 vic=1 we=0", bus.resp_valid, bus.resp_victim, bus.lru_we);
    end
    tick();
    drive(1'b0, TOUCH, 6'd0, 1'b0); #1;
    n_chk++;
    if (bus.resp_valid !== 1'b1 || bus.resp_victim !== 1'b1 || bus.lru_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved got rv=%b vic=%b we=%b exp rv=1 vic=1 we=0", bus.resp_valid, bus.resp_victim, bus.lru_we);
    end
    tick();
    n_chk++;
    if (mem[3] !== 1'b1) begin n_fail++; $display("FAIL query_bit_kept got=%b exp=1", mem[3]); end
    model[3] = 1'b1;
  endtask

  task automatic test_random();
    bit         exp_v, exp_vic, exp_we, exp_wd;
    logic [5:0] exp_addr;
    bit         v, w, old;
    logic [1:0] k;
    logic [5:0] idx;
    exp_v = 1'b0; exp_vic = 1'b0; exp_we = 1'b0; exp_wd = 1'b0; exp_addr = 6'd0;
    for (int c = 0; c < 300; c++) begin
      v   = ($urandom_range(0, 9) < 7);
      k   = 2'($urandom_range(0, 3));
      idx = 6'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      drive(v, k, idx, w); #1;
      n_chk++;
      if (bus.resp_valid !== exp_v || bus.req_ready !== 1'b1 ||
          (exp_v && (bus.resp_victim !== exp_vic || bus.lru_we !== exp_we || bus.lru_addr !== exp_addr ||
                     (exp_we && bus.lru_wdata !== exp_wd)))) begin
        n_fail++;
        $display("FAIL rand[%0d] got rv=%b rdy=%b vic=%b we=%b wd=%b addr=%0d exp rv=%b rdy=1 vic=%b we=%b wd=%b addr=%0d",
                 c, bus.resp_valid, bus.req_ready, bus.resp_victim, bus.lru_we, bus.lru_wdata, bus.lru_addr,
                 exp_v, exp_vic, exp_we, exp_wd, exp_addr);
      end
      exp_v = v;
      if (v) begin
        old      = model[idx];
        exp_vic  = old;
        exp_addr = idx;
        case (k)
          TOUCH:   begin exp_we = 1'b1; exp_wd = ~w;   model[idx] = ~w;   end
          ALLOC:   begin exp_we = 1'b1; exp_wd = ~old; model[idx] = ~old; end
          default: begin exp_we = 1'b0; exp_wd = 1'b0; end
        endcase
      end
      tick();
    end
    drive(1'b0, TOUCH, 6'd0, 1'b0);
    tick();
    for (int i = 0; i < 64; i++) begin
      n_chk++;
      if (mem[i] !== model[i]) begin n_fail++; $display("FAIL rand_bit[%0d] got=%b exp=%b", i, mem[i], model[i]); end
    end
  endtask

  task automatic test_flush_contention();
    bit old;
    old = model[12];
    drive(1'b1, ALLOC, 6'd12, 1'b0); #1; tick();
    bus.flush = 1'b1;
    drive(1'b1, ALLOC, 6'd13, 1'b0); #1;
    n_chk++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_victim !== old ||
        bus.lru_we !== 1'b1 || bus.lru_wdata !== ~old || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_contend got rdy=%b rv=%b vic=%b we=%b wd=%b busy=%b exp rdy=0 rv=1 vic=%b we=1 wd=%b busy=0",
               bus.req_ready, bus.resp_valid, bus.resp_victim, bus.lru_we, bus.lru_wdata, bus.busy, old, ~old);
    end
    tick();
    drive(1'b0, TOUCH, 6'd0, 1'b0);
    check_sweep("flush", 1'b1);
    n_chk++;
    if (mem !== 64'd0) begin n_fail++; $display("FAIL flush_cleared got=%h exp=0", mem); end
  endtask

  task automatic test_mid_op_reset();
    drive(1'b1, ALLOC, 6'd20, 1'b0); #1; tick();
    drive(1'b0, TOUCH, 6'd0, 1'b0);
    rst = 1'b0; #1;
    check_reset_outputs("rst_stage");
    tick();
    rst = 1'b1;
    check_sweep("rst_stage", 1'b0);
    bus.flush = 1'b1; #1; tick();
    bus.flush = 1'b0;
    repeat (30) tick();
    #1;
    n_chk++;
    if (bus.lru_addr !== 6'd30) begin n_fail++; $display("FAIL sweep_at30 got=%0d exp=30", bus.lru_addr); end
    rst = 1'b0; #1;
    check_reset_outputs("rst_sweep");
    tick();
    rst = 1'b1;
    check_sweep("rst_sweep", 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_alloc_touch();
    test_back_to_back();
    test_query_reserved();
    test_random();
    test_flush_contention();
    test_mid_op_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
